// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN transmit arbiter.
package can_tx_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } tx_state_e;

    // Default location of the 29-bit extended identifier in a message word
    localparam int DEF_ID_LSB = 96;
    localparam int DEF_ID_W   = 29;

    // Selection policies
    localparam int MODE_LOWEST_ID = 0;  // lowest identifier, ties to lowest index
    localparam int MODE_FIXED_IDX = 1;  // lowest source index, identifier ignored

endpackage

// File: rtl/can_tx_pick.sv
// Combinational winner selector: linear compare chain over all sources.
module can_tx_pick
    import can_tx_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int MSG_W   = 128,
    parameter int ID_LSB  = DEF_ID_LSB,
    parameter int ID_W    = DEF_ID_W,
    parameter int MODE    = MODE_LOWEST_ID
) (
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*MSG_W-1:0]   src_msg,
    output logic [$clog2(NUM_SRC)-1:0] win_idx,
    output logic                       win_any,
    output logic [MSG_W-1:0]           win_msg
);

    localparam int IW = $clog2(NUM_SRC);

    logic [ID_W-1:0] w_id;
    logic [ID_W-1:0] w_best_id;

    // Walk sources from index 0 upward; a later source only displaces the
    // current best with a strictly lower identifier, so ties stay low.
    always_comb begin
        win_idx   = '0;
        win_any   = 1'b0;
        win_msg   = '0;
        w_id      = '0;
        w_best_id = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_id = src_msg[i*MSG_W+ID_LSB +: ID_W];
            if (src_valid[i] &&
                (!win_any || (MODE == MODE_LOWEST_ID && w_id < w_best_id))) begin
                win_any   = 1'b1;
                win_idx   = IW'(i);
                win_msg   = src_msg[i*MSG_W +: MSG_W];
                w_best_id = w_id;
            end
        end
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// CAN transmit-priority stage: picks a pending message, offers it to the
// bit-stream engine and pops the source on success or retry exhaustion.
module can_tx_arbiter
    import can_tx_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int MSG_W     = 128,
    parameter int ID_LSB    = DEF_ID_LSB,
    parameter int ID_W      = DEF_ID_W,
    parameter int MODE      = MODE_LOWEST_ID,
    parameter int MAX_RETRY = 0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*MSG_W-1:0]   src_msg,
    output logic [NUM_SRC-1:0]         src_pop,
    output logic                       src_drop,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [MSG_W-1:0]           tx_message,
    output logic [$clog2(NUM_SRC)-1:0] tx_src_idx,
    input  logic                       tx_done,
    input  logic                       tx_arb_lost,
    input  logic                       tx_error,
    input  logic                       abort,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int RW = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

    tx_state_e          r_state, w_state_nxt;
    logic [MSG_W-1:0]   r_msg;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      r_last_idx;
    logic [RW-1:0]      r_retry;
    logic [NUM_SRC-1:0] r_pop;
    logic               r_drop;

    logic [IW-1:0]      w_win_idx;
    logic               w_win_any;
    logic [MSG_W-1:0]   w_win_msg;
    logic               w_latch;
    logic [RW-1:0]      w_retry_nxt;
    logic [RW-1:0]      w_retry_inc;
    logic [NUM_SRC-1:0] w_onehot;
    logic [NUM_SRC-1:0] w_pop_nxt;
    logic               w_drop_nxt;

    can_tx_pick #(
        .NUM_SRC (NUM_SRC),
        .MSG_W   (MSG_W),
        .ID_LSB  (ID_LSB),
        .ID_W    (ID_W),
        .MODE    (MODE)
    ) u_pick (
        .src_valid (src_valid),
        .src_msg   (src_msg),
        .win_idx   (w_win_idx),
        .win_any   (w_win_any),
        .win_msg   (w_win_msg)
    );

    // Pop vector for the source currently behind tx_message; saturating retry+1
    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
        w_retry_inc     = (r_retry == '1) ? r_retry : r_retry + 1'b1;
    end

    // Next state, latch strobe, retry counter and pop/drop pulses
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_retry_nxt = r_retry;
        w_pop_nxt   = '0;
        w_drop_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                // Hold off while a pop is in flight: the source has not yet
                // presented its next head, so src_valid/src_msg are stale.
                if (w_win_any && r_pop == '0) begin
                    w_latch     = 1'b1;
                    w_state_nxt = OFFER;
                    if (w_win_idx != r_last_idx)
                        w_retry_nxt = '0;
                end
            end
            OFFER: begin
                if (tx_ready)
                    w_state_nxt = BUSY;
                else if (abort || !src_valid[r_idx])
                    w_state_nxt = IDLE;
            end
            BUSY: begin
                if (tx_done) begin
                    w_pop_nxt   = w_onehot;
                    w_retry_nxt = '0;
                    w_state_nxt = IDLE;
                end else if (tx_arb_lost || tx_error) begin
                    w_state_nxt = IDLE;
                    if (MAX_RETRY != 0 && w_retry_inc == RW'(MAX_RETRY)) begin
                        w_pop_nxt   = w_onehot;
                        w_drop_nxt  = 1'b1;
                        w_retry_nxt = '0;
                    end else begin
                        w_retry_nxt = w_retry_inc;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Offered message, source index, retry bookkeeping and output pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_msg      <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_retry    <= '0;
            r_pop      <= '0;
            r_drop     <= 1'b0;
        end else begin
            if (w_latch) begin
                r_msg      <= w_win_msg;
                r_idx      <= w_win_idx;
                r_last_idx <= w_win_idx;
            end
            r_retry <= w_retry_nxt;
            r_pop   <= w_pop_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign tx_valid   = (r_state == OFFER);
    assign busy       = (r_state != IDLE);
    assign tx_message = r_msg;
    assign tx_src_idx = r_idx;
    assign src_pop    = r_pop;
    assign src_drop   = r_drop;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Bench for can_tx_arbiter: a lowest-ID instance with MAX_RETRY=3 and a
// fixed-index instance retrying forever share one set of stimulus.
module tb_can_tx_arbiter;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic [2:0]   src_valid;
    logic [383:0] src_msg;
    logic         tx_ready, tx_done, tx_arb_lost, tx_error, abort;

    logic [2:0]   o0_pop,  o1_pop;
    logic         o0_drop, o1_drop, o0_valid, o1_valid, o0_busy, o1_busy;
    logic [127:0] o0_msg,  o1_msg;
    logic [1:0]   o0_idx,  o1_idx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    can_tx_arbiter #(.NUM_SRC(3), .MSG_W(128), .ID_LSB(96), .ID_W(29),
                     .MODE(0), .MAX_RETRY(3)) u0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .src_valid(src_valid), .src_msg(src_msg),
        .src_pop(o0_pop), .src_drop(o0_drop),
        .tx_valid(o0_valid), .tx_ready(tx_ready),
        .tx_message(o0_msg), .tx_src_idx(o0_idx),
        .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error),
        .abort(abort), .busy(o0_busy));

    can_tx_arbiter #(.NUM_SRC(3), .MSG_W(128), .ID_LSB(96), .ID_W(29),
                     .MODE(1), .MAX_RETRY(0)) u1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .src_valid(src_valid), .src_msg(src_msg),
        .src_pop(o1_pop), .src_drop(o1_drop),
        .tx_valid(o1_valid), .tx_ready(tx_ready),
        .tx_message(o1_msg), .tx_src_idx(o1_idx),
        .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error),
        .abort(abort), .busy(o1_busy));

    typedef struct {
        logic [2:0]  vld;
        logic [28:0] id0, id1, id2;
        logic [1:0]  exp0, exp1;
    } vec_t;

    vec_t tbl [8];

    // Reference source FIFOs for the random phase
    logic [28:0] qid  [3][$];
    int          qtag [3][$];
    int          tagc = 1000;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [28:0] id, input int tag);
        logic [127:0] m;
        m          = '0;
        m[96 +: 29] = id;
        m[63:32]   = ~tag;
        m[31:0]    = tag;
        return m;
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [28:0] id, input int tag);
        src_msg[s*128 +: 128] = mk(id, tag);
    endtask

    task automatic go_idle();
        src_valid = 3'b000;
        step();
        chk("idle_busy0", o0_busy, 1'b0);
        chk("idle_busy1", o1_busy, 1'b0);
    endtask

    // One offer -> accept -> tx_error round; returns to IDLE
    task automatic err_round(input logic exp_drop);
        step();
        chk("err_offer", o0_valid, 1'b1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        tx_error = 1'b1;
        step();
        tx_error = 1'b0;
        chk("err_pop",   o0_pop,  exp_drop ? 3'b001 : 3'b000);
        chk("err_drop",  o0_drop, exp_drop);
        chk("err_drop1", o1_drop, 1'b0);
    endtask

    task automatic drive_srcs();
        for (int s = 0; s < 3; s++) begin
            src_valid[s] = (qid[s].size() > 0);
            if (qid[s].size() > 0) set_src(s, qid[s][0], qtag[s][0]);
            else                   src_msg[s*128 +: 128] = '0;
        end
    endtask

    task automatic push_rand();
        int s;
        s = $urandom_range(0, 2);
        if (qid[s].size() < 4) begin
            qid[s].push_back(29'($urandom_range(0, 15)));
            qtag[s].push_back(tagc);
            tagc++;
        end
    endtask

    // Winner by rule: smallest head identifier, first source holding it
    function automatic int model_winner();
        logic [29:0] mn;
        mn = 30'h3FFF_FFFF;
        for (int s = 0; s < 3; s++)
            if (qid[s].size() > 0 && {1'b0, qid[s][0]} < mn) mn = {1'b0, qid[s][0]};
        for (int s = 0; s < 3; s++)
            if (qid[s].size() > 0 && {1'b0, qid[s][0]} == mn) return s;
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp, last, cnt, o;
        logic got, pop_exp, drop_exp;
        logic [28:0] ids [3];

        tbl[0] = '{3'b111, 29'h120, 29'h0A5, 29'h0A5, 2'd1, 2'd0};
        tbl[1] = '{3'b110, 29'h120, 29'h0A5, 29'h0A5, 2'd1, 2'd1};
        tbl[2] = '{3'b100, 29'h120, 29'h0A5, 29'h0A5, 2'd2, 2'd2};
        tbl[3] = '{3'b101, 29'h300, 29'h0A5, 29'h001, 2'd2, 2'd0};
        tbl[4] = '{3'b111, 29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFE, 2'd2, 2'd0};
        tbl[5] = '{3'b111, 29'h0, 29'h0, 29'h0, 2'd0, 2'd0};
        tbl[6] = '{3'b011, 29'h5, 29'h4, 29'h0, 2'd1, 2'd0};
        tbl[7] = '{3'b111, 29'h7, 29'h1FFFFFFF, 29'h7, 2'd0, 2'd0};

        sys_rst_n = 1'b0;
        src_valid = '0; src_msg = '0;
        tx_ready = 0; tx_done = 0; tx_arb_lost = 0; tx_error = 0; abort = 0;
        #12;
        chk("rst_valid", o0_valid, 1'b0);
        chk("rst_busy",  o0_busy,  1'b0);
        chk("rst_pop",   o0_pop,   3'b000);
        chk("rst_drop",  o0_drop,  1'b0);
        chk("rst_msg",   o0_msg,   128'd0);
        chk("rst_idx",   o0_idx,   2'd0);
        chk("rst_msg1",  o1_msg,   128'd0);
        sys_rst_n = 1'b1;
        step();

        // Selection table: offer appears one edge after src_valid
        for (int v = 0; v < 8; v++) begin
            ids[0] = tbl[v].id0; ids[1] = tbl[v].id1; ids[2] = tbl[v].id2;
            for (int s = 0; s < 3; s++) set_src(s, ids[s], v*16 + s);
            src_valid = tbl[v].vld;
            step();
            chk($sformatf("tbl%0d_valid0", v), o0_valid, 1'b1);
            chk($sformatf("tbl%0d_valid1", v), o1_valid, 1'b1);
            chk($sformatf("tbl%0d_idx0", v), o0_idx, tbl[v].exp0);
            chk($sformatf("tbl%0d_idx1", v), o1_idx, tbl[v].exp1);
            chk($sformatf("tbl%0d_msg0", v), o0_msg, mk(ids[tbl[v].exp0], v*16 + int'(tbl[v].exp0)));
            chk($sformatf("tbl%0d_msg1", v), o1_msg, mk(ids[tbl[v].exp1], v*16 + int'(tbl[v].exp1)));
            go_idle();
        end

        // Done -> pop pulse, then 2-cycle turnaround to the next offer
        set_src(0, 29'h120, 1); set_src(1, 29'h0A5, 2); set_src(2, 29'h0A5, 3);
        src_valid = 3'b111;
        step();
        chk("a_idx0", o0_idx, 2'd1);
        chk("a_idx1", o1_idx, 2'd0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("a_busy", o0_busy, 1'b1);
        chk("a_txv_fall", o0_valid, 1'b0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("a_pop0", o0_pop, 3'b010);
        chk("a_pop1", o1_pop, 3'b001);
        chk("a_idle", o0_busy, 1'b0);
        src_valid = 3'b110;
        step();
        chk("a_pop_one", o0_pop, 3'b000);
        chk("a_turn", o1_valid, 1'b0);
        step();
        chk("a_reoffer", o1_valid, 1'b1);
        chk("a_next1", o1_idx, 2'd1);
        go_idle();

        // Lost arbitration while a higher-priority message arrives
        set_src(1, 29'h200, 5);
        src_valid = 3'b010;
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        tx_arb_lost = 1'b1;
        set_src(0, 29'h010, 6);
        src_valid = 3'b011;
        step();
        tx_arb_lost = 1'b0;
        chk("b_nopop", o0_pop, 3'b000);
        chk("b_idle", o0_busy, 1'b0);
        step();
        chk("b_valid", o0_valid, 1'b1);
        chk("b_idx", o0_idx, 2'd0);
        go_idle();

        // Retry exhaustion on a single source
        set_src(0, 29'h055, 7);
        src_valid = 3'b001;
        err_round(1'b0);
        err_round(1'b0);
        err_round(1'b1);
        src_valid = 3'b000;
        step();
        step();

        // Abort / flush in OFFER, abort in BUSY, done beats error
        src_valid = 3'b001;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("d_abort_drop", o0_valid, 1'b0);
        chk("d_abort_nopop", o0_pop, 3'b000);
        step();
        chk("d_reoffer", o0_valid, 1'b1);
        src_valid = 3'b000;
        step();
        chk("d_flush_drop", o0_valid, 1'b0);
        src_valid = 3'b001;
        step();
        chk("d_flush_reoffer", o0_valid, 1'b1);
        tx_done = 1'b1; tx_error = 1'b1;
        step();
        tx_done = 1'b0; tx_error = 1'b0;
        chk("d_offer_ignores_done", o0_valid, 1'b1);
        chk("d_offer_nopop", o0_pop, 3'b000);
        tx_ready = 1'b1; abort = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("d_ready_wins", o0_busy, 1'b1);
        step();
        abort = 1'b0;
        chk("d_busy_abort", o0_busy, 1'b1);
        tx_done = 1'b1; tx_error = 1'b1;
        step();
        tx_done = 1'b0; tx_error = 1'b0;
        chk("d_done_pop", o0_pop, 3'b001);
        chk("d_done_nodrop", o0_drop, 1'b0);
        src_valid = 3'b000;
        step();
        step();

        // Reset in BUSY, then retry count must restart from zero
        src_valid = 3'b001;
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0; tx_error = 1'b1;
        step();
        tx_error = 1'b0;
        step();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("f_busy", o0_busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        chk("f_rst_busy", o0_busy, 1'b0);
        chk("f_rst_msg", o0_msg, 128'd0);
        chk("f_rst_pop", o0_pop, 3'b000);
        step();
        #2 sys_rst_n = 1'b1;
        err_round(1'b0);
        err_round(1'b0);
        err_round(1'b1);
        src_valid = 3'b000;
        step();
        step();

        // Randomized traffic on the lowest-ID instance against the queue model
        last = 0; cnt = 0;
        for (int t = 0; t < 300; t++) begin
            if (qid[0].size() + qid[1].size() + qid[2].size() == 0) push_rand();
            drive_srcs();
            got = 1'b0;
            for (int c = 0; c < 4 && !got; c++) begin
                step();
                if (o0_valid) got = 1'b1;
            end
            if (!got) begin
                n_chk++; n_fail++;
                $display("FAIL rnd_timeout: no offer within 4 cycles at txn %0d", t);
                break;
            end
            exp = model_winner();
            chk("rnd_idx", o0_idx, exp);
            chk("rnd_msg", o0_msg, mk(qid[exp][0], qtag[exp][0]));
            if (exp != last) cnt = 0;
            last = exp;
            if ($urandom_range(0, 7) == 0) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("rnd_abort", o0_busy, 1'b0);
                continue;
            end
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
            chk("rnd_busy", o0_busy, 1'b1);
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                abort = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin push_rand(); drive_srcs(); end
                step();
                chk("rnd_wait_nopop", o0_pop, 3'b000);
            end
            abort = 1'b0;
            o = $urandom_range(0, 3);
            tx_done     = (o == 0 || o == 3);
            tx_arb_lost = (o == 1 || o == 3);
            tx_error    = (o == 2);
            step();
            tx_done = 0; tx_arb_lost = 0; tx_error = 0;
            pop_exp = 1'b0; drop_exp = 1'b0;
            if (o == 0 || o == 3) begin
                pop_exp = 1'b1; cnt = 0;
            end else begin
                cnt++;
                if (cnt == 3) begin pop_exp = 1'b1; drop_exp = 1'b1; cnt = 0; end
            end
            chk("rnd_pop", o0_pop, pop_exp ? (3'b001 << exp) : 3'b000);
            chk("rnd_drop", o0_drop, drop_exp);
            chk("rnd_idle", o0_busy, 1'b0);
            if (pop_exp) begin
                void'(qid[exp].pop_front());
                void'(qtag[exp].pop_front());
                if ($urandom_range(0, 1) == 1) push_rand();
                drive_srcs();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
